// File: rtl/whitening_pkg.sv
// Shared types and sizing helpers for the whitening covariance stage.
package whitening_pkg;

  // Covariance sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC,
    S_DRAIN,
    S_DIV,
    S_WR,
    S_DONE
  } cov_state_t;

  // Default samples per channel (power of two).
  localparam int DEF_N_SAMP = 128;

  // Number of upper-triangular channel pairs (i <= j).
  function automatic int pair_count(input int n_ch);
    return n_ch * (n_ch + 1) / 2;
  endfunction

  // Select width for n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cov_pair_sequencer.sv
// Walks the upper-triangular channel pairs (0,0),(0,1)..(N-1,N-1) and keeps
// the matching result index. Advances only when the controller pulses adv.
module cov_pair_sequencer
  import whitening_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int CW   = sel_width(N_CH),
  parameter int NP   = pair_count(N_CH),
  parameter int PW   = sel_width(NP)
) (
  input  logic          CLK_cov,
  input  logic          GO_cov,
  input  logic          adv,
  output logic [CW-1:0] ch_a,
  output logic [CW-1:0] ch_b,
  output logic [PW-1:0] pair_idx,
  output logic          last
);

  localparam logic [CW-1:0] CH_MAX   = CW'(N_CH - 1);
  localparam logic [PW-1:0] PAIR_MAX = PW'(NP - 1);

  // Final pair is decoded from the registered pair index only.
  assign last = (pair_idx == PAIR_MAX);

  // Pair registers: wrap ch_b back onto the diagonal when it reaches the last channel.
  always_ff @(posedge CLK_cov or negedge GO_cov) begin
    if (!GO_cov) begin
      ch_a     <= '0;
      ch_b     <= '0;
      pair_idx <= '0;
    end else if (adv) begin
      if (ch_b == CH_MAX) begin
        ch_a <= ch_a + 1'b1;
        ch_b <= ch_a + 1'b1;
      end else begin
        ch_b <= ch_b + 1'b1;
      end
      pair_idx <= pair_idx + 1'b1;
    end
  end

endmodule

// File: rtl/covariance_controller.sv
// Sequencer for the whitening covariance stage. For every channel pair it
// clears the accumulator, streams N_SAMP sample addresses into the MAC,
// then strobes divide and write-back. All outputs come from registers.
module covariance_controller
  import whitening_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int N_SAMP = DEF_N_SAMP,
  parameter int AW     = $clog2(N_SAMP),
  parameter int CW     = sel_width(N_CH),
  parameter int NP     = pair_count(N_CH),
  parameter int PW     = sel_width(NP)
) (
  input  logic          CLK_cov,
  input  logic          GO_cov,
  input  logic          HOLD_cov,
  output logic [AW-1:0] samp_addr,
  output logic [CW-1:0] ch_a,
  output logic [CW-1:0] ch_b,
  output logic [PW-1:0] cov_addr,
  output logic          En_RD,
  output logic          Clr_ACC,
  output logic          En_MAC,
  output logic          En_DIV,
  output logic          En_WR,
  output logic          COV_Busy,
  output logic          COV_Done
);

  // cnt holds the next address to issue; one extra bit marks "all issued".
  localparam logic [AW:0] CNT_END = (AW + 1)'(N_SAMP);

  cov_state_t  state;
  logic [AW:0] cnt;
  logic        adv;
  logic        last;

  // Move to the next pair on the write-back cycle unless this was the last one.
  assign adv = (state == S_WR) && !last;

  cov_pair_sequencer #(
    .N_CH(N_CH),
    .CW  (CW),
    .NP  (NP),
    .PW  (PW)
  ) u_pairs (
    .CLK_cov (CLK_cov),
    .GO_cov  (GO_cov),
    .adv     (adv),
    .ch_a    (ch_a),
    .ch_b    (ch_b),
    .pair_idx(cov_addr),
    .last    (last)
  );

  // Main sequencer: state, sample counter and registered strobes.
  always_ff @(posedge CLK_cov or negedge GO_cov) begin
    if (!GO_cov) begin
      state     <= S_IDLE;
      cnt       <= '0;
      samp_addr <= '0;
      En_RD     <= 1'b0;
      Clr_ACC   <= 1'b0;
      En_DIV    <= 1'b0;
      En_WR     <= 1'b0;
      COV_Busy  <= 1'b0;
      COV_Done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_CLR;
          Clr_ACC  <= 1'b1;
          COV_Busy <= 1'b1;
        end
        S_CLR: begin
          // First address goes out unconditionally; hold only applies in S_MAC.
          Clr_ACC   <= 1'b0;
          state     <= S_MAC;
          En_RD     <= 1'b1;
          samp_addr <= '0;
          cnt       <= (AW + 1)'(1);
        end
        S_MAC: begin
          if (cnt == CNT_END) begin
            state     <= S_DRAIN;
            En_RD     <= 1'b0;
            samp_addr <= '0;
          end else if (HOLD_cov) begin
            En_RD <= 1'b0;
          end else begin
            En_RD     <= 1'b1;
            samp_addr <= cnt[AW-1:0];
            cnt       <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          state  <= S_DIV;
          En_DIV <= 1'b1;
          cnt    <= '0;
        end
        S_DIV: begin
          En_DIV <= 1'b0;
          En_WR  <= 1'b1;
          state  <= S_WR;
        end
        S_WR: begin
          En_WR <= 1'b0;
          if (last) begin
            state    <= S_DONE;
            COV_Busy <= 1'b0;
            COV_Done <= 1'b1;
          end else begin
            state   <= S_CLR;
            Clr_ACC <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // MAC data is valid one cycle after the read strobe (RAM read latency).
  always_ff @(posedge CLK_cov or negedge GO_cov) begin
    if (!GO_cov) begin
      En_MAC <= 1'b0;
    end else begin
      En_MAC <= En_RD;
    end
  end

endmodule

// File: tb/tb_covariance_controller.sv
// Self-checking bench for covariance_controller (N_CH=2 and N_CH=3 instances).
module tb_covariance_controller;

  localparam int MAXE = 2000;
  localparam int NS   = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       go2, hold2, go3, hold3;
  logic [6:0] sa2, sa3;
  logic       ca2, cb2;
  logic [1:0] ca3, cb3;
  logic [1:0] cov2;
  logic [2:0] cov3;
  logic rd2, clr2, mac2, div2, wr2, busy2, done2;
  logic rd3, clr3, mac3, div3, wr3, busy3, done3;

  covariance_controller #(.N_CH(2), .N_SAMP(NS)) dut2 (
    .CLK_cov(clk), .GO_cov(go2), .HOLD_cov(hold2), .samp_addr(sa2),
    .ch_a(ca2), .ch_b(cb2), .cov_addr(cov2), .En_RD(rd2), .Clr_ACC(clr2),
    .En_MAC(mac2), .En_DIV(div2), .En_WR(wr2), .COV_Busy(busy2), .COV_Done(done2));

  covariance_controller #(.N_CH(3), .N_SAMP(NS)) dut3 (
    .CLK_cov(clk), .GO_cov(go3), .HOLD_cov(hold3), .samp_addr(sa3),
    .ch_a(ca3), .ch_b(cb3), .cov_addr(cov3), .En_RD(rd3), .Clr_ACC(clr3),
    .En_MAC(mac3), .En_DIV(div3), .En_WR(wr3), .COV_Busy(busy3), .COV_Done(done3));

  int sel;
  int o_sa, o_ca, o_cb, o_cov, o_rd, o_clr, o_mac, o_div, o_wr, o_busy, o_done;

  always_comb begin
    if (sel == 3) begin
      o_sa = int'(sa3); o_ca = int'(ca3); o_cb = int'(cb3); o_cov = int'(cov3);
      o_rd = int'(rd3); o_clr = int'(clr3); o_mac = int'(mac3); o_div = int'(div3);
      o_wr = int'(wr3); o_busy = int'(busy3); o_done = int'(done3);
    end else begin
      o_sa = int'(sa2); o_ca = int'(ca2); o_cb = int'(cb2); o_cov = int'(cov2);
      o_rd = int'(rd2); o_clr = int'(clr2); o_mac = int'(mac2); o_div = int'(div2);
      o_wr = int'(wr2); o_busy = int'(busy2); o_done = int'(done2);
    end
  end

  // Expected schedule, indexed by edge number (outputs seen after that edge).
  int exp_rd[MAXE], exp_addr[MAXE], exp_mac[MAXE], exp_clr[MAXE], exp_div[MAXE];
  int exp_wr[MAXE], exp_busy[MAXE], exp_done[MAXE], exp_ca[MAXE], exp_cb[MAXE], exp_cov[MAXE];
  int hold_at[MAXE];
  int obs_rd[MAXE], obs_addr[MAXE], obs_mac[MAXE], obs_clr[MAXE], obs_wr[MAXE];
  int obs_busy[MAXE], obs_done[MAXE], obs_ca[MAXE], obs_cb[MAXE], obs_cov[MAXE];
  int done_edge;
  int n_tests, n_fail, cur_e;

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s (dut N_CH=%0d, edge %0d): got %0d, expected %0d", nm, sel, cur_e, act, expv);
    end
  endtask

  task automatic set_go(input logic v);
    if (sel == 3) go3 = v; else go2 = v;
  endtask

  task automatic set_hold(input int v);
    if (sel == 3) hold3 = (v != 0); else hold2 = (v != 0);
  endtask

  task automatic clear_holds();
    for (int t = 0; t < MAXE; t++) hold_at[t] = 0;
  endtask

  task automatic rand_holds();
    for (int t = 0; t < MAXE; t++) hold_at[t] = ($urandom_range(0, 7) == 0) ? 1 : 0;
  endtask

  // Schedule model: each pair is clear, N_SAMP issued addresses (edges that
  // sample HOLD high while streaming are skipped), drain, divide, write.
  task automatic build_model(input int nch);
    int e, p, s, ae, dr;
    for (int t = 0; t < MAXE; t++) begin
      exp_rd[t] = 0; exp_addr[t] = 0; exp_mac[t] = 0; exp_clr[t] = 0; exp_div[t] = 0;
      exp_wr[t] = 0; exp_busy[t] = 0; exp_done[t] = 0; exp_ca[t] = 0; exp_cb[t] = 0; exp_cov[t] = 0;
    end
    e = 1; p = 0;
    for (int i = 0; i < nch; i++) begin
      for (int j = i; j < nch; j++) begin
        s = e;
        exp_clr[s] = 1;
        ae = s + 1;
        for (int k = 0; k < NS; k++) begin
          if (k > 0) begin
            ae++;
            while (ae < MAXE - 10 && hold_at[ae] != 0) ae++;
          end
          exp_rd[ae] = 1; exp_addr[ae] = k; exp_mac[ae + 1] = 1;
        end
        dr = ae + 1;
        exp_div[dr + 1] = 1;
        exp_wr[dr + 2] = 1;
        for (int t = s; t <= dr + 2; t++) begin
          exp_busy[t] = 1; exp_ca[t] = i; exp_cb[t] = j; exp_cov[t] = p;
        end
        e = dr + 3;
        p++;
      end
    end
    done_edge = e;
    for (int t = e; t < MAXE; t++) exp_done[t] = 1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".samp_addr"}, o_sa, 0);  chk({tag, ".ch_a"}, o_ca, 0);
    chk({tag, ".ch_b"}, o_cb, 0);       chk({tag, ".cov_addr"}, o_cov, 0);
    chk({tag, ".En_RD"}, o_rd, 0);      chk({tag, ".Clr_ACC"}, o_clr, 0);
    chk({tag, ".En_MAC"}, o_mac, 0);    chk({tag, ".En_DIV"}, o_div, 0);
    chk({tag, ".En_WR"}, o_wr, 0);      chk({tag, ".COV_Busy"}, o_busy, 0);
    chk({tag, ".COV_Done"}, o_done, 0);
  endtask

  task automatic check_outputs(input int e);
    chk("En_RD", o_rd, exp_rd[e]);
    if (exp_rd[e] != 0) chk("samp_addr", o_sa, exp_addr[e]);
    chk("En_MAC", o_mac, exp_mac[e]);
    chk("Clr_ACC", o_clr, exp_clr[e]);
    chk("En_DIV", o_div, exp_div[e]);
    chk("En_WR", o_wr, exp_wr[e]);
    chk("COV_Busy", o_busy, exp_busy[e]);
    chk("COV_Done", o_done, exp_done[e]);
    if (exp_busy[e] != 0) begin
      chk("ch_a", o_ca, exp_ca[e]);
      chk("ch_b", o_cb, exp_cb[e]);
      chk("cov_addr", o_cov, exp_cov[e]);
    end
  endtask

  // One GO_cov-high run; abort_e > 0 drops GO_cov just after that edge.
  task automatic run(input int s, input int nch, input int abort_e, input int extra);
    sel = s;
    build_model(nch);
    for (int t = 0; t < MAXE; t++) begin
      obs_rd[t] = 0; obs_addr[t] = 0; obs_mac[t] = 0; obs_clr[t] = 0; obs_wr[t] = 0;
      obs_busy[t] = 0; obs_done[t] = 0; obs_ca[t] = 0; obs_cb[t] = 0; obs_cov[t] = 0;
    end
    @(negedge clk);
    set_hold(hold_at[1]);
    set_go(1'b1);
    for (int e = 1; e <= done_edge + extra && e < MAXE - 2; e++) begin
      @(negedge clk);
      cur_e = e;
      obs_rd[e] = o_rd; obs_addr[e] = o_sa; obs_mac[e] = o_mac; obs_clr[e] = o_clr;
      obs_wr[e] = o_wr; obs_busy[e] = o_busy; obs_done[e] = o_done;
      obs_ca[e] = o_ca; obs_cb[e] = o_cb; obs_cov[e] = o_cov;
      check_outputs(e);
      if (e == abort_e) begin
        #2;
        set_go(1'b0);
        #1;
        check_zero("abort");
        break;
      end
      set_hold(hold_at[e + 1]);
    end
    set_go(1'b0);
    set_hold(0);
    @(negedge clk);
    check_zero("idle");
  endtask

  task automatic check_beats(input int np);
    int c;
    for (int p = 0; p < np; p++) begin
      c = 0;
      for (int t = 1; t < MAXE; t++)
        if (obs_mac[t] != 0 && obs_busy[t] != 0 && obs_cov[t] == p) c++;
      chk($sformatf("mac_beats_pair%0d", p), c, NS);
    end
  endtask

  initial begin
    int exp_a[6];
    int exp_b[6];
    exp_a = '{0, 0, 0, 1, 1, 2};
    exp_b = '{0, 1, 2, 1, 2, 2};
    go2 = 1'b0; go3 = 1'b0; hold2 = 1'b0; hold3 = 1'b0;
    n_tests = 0; n_fail = 0; cur_e = 0; sel = 2;

    repeat (3) @(negedge clk);
    check_zero("reset2");
    sel = 3;
    #1;
    check_zero("reset3");

    // N_CH=2, no holds: fixed edge numbers.
    clear_holds();
    run(2, 2, 0, 4);
    cur_e = 0;
    chk("lit_clr@1", obs_clr[1], 1);
    chk("lit_mac@2", obs_mac[2], 0);
    chk("lit_mac@3", obs_mac[3], 1);
    chk("lit_addr@2", obs_addr[2], 0);
    chk("lit_addr@129", obs_addr[129], 127);
    chk("lit_wr@131", obs_wr[131], 0);
    chk("lit_wr@132", obs_wr[132], 1);
    chk("lit_cov@132", obs_cov[132], 0);
    chk("lit_wr@264", obs_wr[264], 1);
    chk("lit_cov@264", obs_cov[264], 1);
    chk("lit_wr@396", obs_wr[396], 1);
    chk("lit_cov@396", obs_cov[396], 2);
    chk("lit_done@396", obs_done[396], 0);
    chk("lit_done@397", obs_done[397], 1);
    chk("lit_busy@397", obs_busy[397], 0);
    check_beats(3);

    // 5-cycle hold at address 40, holds across drain/div/write and in S_DONE.
    clear_holds();
    for (int t = 43; t <= 47; t++) hold_at[t] = 1;
    for (int t = 136; t <= 139; t++) hold_at[t] = 1;
    for (int t = 399; t < MAXE; t++) hold_at[t] = 1;
    run(2, 2, 0, 8);
    cur_e = 0;
    chk("hold_addr@42", obs_addr[42], 40);
    chk("hold_addr@45", obs_addr[45], 40);
    chk("hold_rd@45", obs_rd[45], 0);
    chk("hold_mac@43", obs_mac[43], 1);
    chk("hold_mac@44", obs_mac[44], 0);
    chk("hold_mac@48", obs_mac[48], 0);
    chk("hold_rd@48", obs_rd[48], 1);
    chk("hold_addr@48", obs_addr[48], 41);
    chk("hold_wr@137", obs_wr[137], 1);
    chk("hold_clr@138", obs_clr[138], 1);
    chk("hold_wr@401", obs_wr[401], 1);
    chk("hold_done@402", obs_done[402], 1);
    chk("hold_done@410", obs_done[410], 1);
    check_beats(3);

    // Abort mid pair 1, then restart from pair 0 with random holds.
    rand_holds();
    run(2, 2, 199, 0);
    rand_holds();
    run(2, 2, 0, 3);
    cur_e = 0;
    chk("restart_clr@1", obs_clr[1], 1);
    chk("restart_cov@1", obs_cov[1], 0);
    check_beats(3);

    // N_CH=3, no holds: six pairs in order.
    clear_holds();
    run(3, 3, 0, 4);
    cur_e = 0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("n3_wr@%0d", 132 * k), obs_wr[132 * k], 1);
      chk($sformatf("n3_cov@%0d", 132 * k), obs_cov[132 * k], k - 1);
      chk($sformatf("n3_cha@%0d", 132 * k), obs_ca[132 * k], exp_a[k - 1]);
      chk($sformatf("n3_chb@%0d", 132 * k), obs_cb[132 * k], exp_b[k - 1]);
    end
    chk("n3_done@792", obs_done[792], 0);
    chk("n3_done@793", obs_done[793], 1);
    check_beats(6);

    // Random holds on both configurations.
    rand_holds();
    run(3, 3, 0, 5);
    cur_e = 0;
    check_beats(6);
    rand_holds();
    run(2, 2, 0, 5);
    cur_e = 0;
    check_beats(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/covariance_controller.md
# covariance_controller

Sequencer for the whitening covariance stage: after centering has left zero-mean samples in sample RAM, this block walks every upper-triangular channel pair (i ≤ j). For each pair it clears the accumulator, streams N_SAMP sample addresses into the multiply-accumulate datapath, then triggers the divide-by-N_SAMP and the write-back of C[i][j]. It owns no arithmetic; it only drives enables, addresses and channel selects for the covariance datapath and reports busy/done to the whitening top-level sequencer.

## Interface
- N_CH, 2: number of signal channels (2..8).
- N_SAMP, 128: samples per channel; power of two.
- AW, log2(N_SAMP): sample address width.
- CW, max(1, ceil(log2(N_CH))): channel select width.
- NP, N_CH*(N_CH+1)/2: number of pairs.
- PW, max(1, ceil(log2(NP))): covariance address width.
- CLK_cov  in  1  clock; all datapath clocks derive from it.
- GO_cov  in  1  asynchronous active-low reset; low = reset, high = run. One clock, reset asynchronous and active-low.
- HOLD_cov  in  1  stall request from sample-RAM arbiter; honoured only in S_MAC.
- samp_addr  out  AW  sample RAM read address.
- ch_a, ch_b  out  CW each  channel selects of the current pair (ch_a ≤ ch_b).
- cov_addr  out  PW  result RAM write address = pair index.
- En_RD  out  1  sample RAM read strobe.
- Clr_ACC  out  1  accumulator clear.
- En_MAC  out  1  accumulate x[ch_a]·x[ch_b]; data valid.
- En_DIV  out  1  divide accumulator by N_SAMP (shift by AW).
- En_WR  out  1  write divided result to cov_addr.
- COV_Busy  out  1  sequence in progress.
- COV_Done  out  1  all NP pairs written; held until GO_cov low.

## Operation
- All outputs are registered or decoded from registered state only; there are no input→output combinational paths.
- Reset (GO_cov low) values:
  - all outputs 0;
  - state S_IDLE;
  - counters, ch_a, ch_b and pair index 0.
- States:
  - S_IDLE → S_CLR on the first edge with GO_cov high; sets COV_Busy=1.
  - S_CLR: Clr_ACC=1 for one cycle → S_MAC with cnt=0.
  - S_MAC: En_RD=1 and samp_addr=cnt. cnt increments each non-held cycle. After address N_SAMP-1 is issued → S_DRAIN.
  - S_DRAIN: En_RD=0. Last En_MAC beat occurs here → S_DIV.
  - S_DIV: En_DIV=1 for one cycle → S_WR.
  - S_WR: En_WR=1 and cov_addr=pair index. If the pair index = NP-1 → S_DONE; else advance the pair → S_CLR.
  - S_DONE: COV_Busy=0, COV_Done=1; all enables 0. The block stays here until GO_cov goes low.
- En_MAC is En_RD delayed one cycle, matching the 1-cycle RAM read latency. This gives exactly N_SAMP En_MAC beats per pair, independent of holds.
- Hold handling: HOLD_cov=1 in S_MAC forces En_RD=0 and freezes cnt/samp_addr; the next cycle has En_MAC=0. HOLD_cov is ignored in every other state.
- Pair advance order: (0,0),(0,1)…(0,N-1),(1,1)…(N-1,N-1).
  - If ch_b = N_CH-1: ch_a+1, ch_b = ch_a+1.
  - Otherwise: ch_b+1.
  - The pair index increments on every advance.
- ch_a, ch_b and cov_addr stay stable from S_CLR through S_WR of a pair.
- GO_cov low at any time aborts immediately to reset values. No partial result is flagged; the next GO_cov rise restarts from pair 0.

## Timing
- Edge numbering: edge 1 is the first rising edge with GO_cov high.
- Pair p occupies edges 1+132p .. 132+132p (for N_SAMP=128, no holds):
  - S_CLR at edge 1+132p;
  - S_MAC at edges 2..129 (+132p);
  - S_DRAIN at 130, S_DIV at 131, S_WR at 132 (+132p).
- En_MAC is high after edges 3..130 (+132p).
- General pair period: N_SAMP+4 cycles, plus one cycle per held S_MAC cycle.
- For N_CH=2: last En_WR after edge 396; COV_Done=1 and COV_Busy=0 from edge 397.
- A HOLD_cov asserted during S_DRAIN/S_DIV/S_WR has no effect.

## Structure
- Shared package `whitening_pkg`:
  - state enum (S_IDLE, S_CLR, S_MAC, S_DRAIN, S_DIV, S_WR, S_DONE);
  - NP/PW helper constant function;
  - default N_SAMP.
- Sub-module `cov_pair_sequencer`: holds ch_a/ch_b/pair index with `adv` and `last` outputs. The FSM plus sample counter stay in `covariance_controller`.

## Test plan
- N_CH=2, N_SAMP=128, no holds. Expect:
  - 3 pairs (0,0),(0,1),(1,1);
  - En_WR at edges 132/264/396 with cov_addr 0/1/2;
  - COV_Done at 397.
- Per pair: count En_MAC beats = 128, each one cycle after En_RD with samp_addr 0..127 in order; Clr_ACC precedes the first beat by 2 cycles.
- HOLD_cov high for 5 cycles at samp_addr=40. Expect:
  - samp_addr frozen at 40;
  - En_MAC gap of 5 cycles;
  - still 128 beats;
  - pair end delayed 5 cycles.
- GO_cov low at edge 200 (mid pair 1). Expect all outputs 0 at once; after re-rise, pair (0,0) restarts with Clr_ACC at edge 1.
- N_CH=3. Expect 6 pairs in order (0,0),(0,1),(0,2),(1,1),(1,2),(2,2) with cov_addr 0..5 and COV_Done after 6·132 edges.
- HOLD_cov held high during S_DONE and S_WR. Expect no state change; COV_Done stays 1 until GO_cov low.
